// File: rtl/riscv_decode_pkg.sv
// Shared encodings for the RV32I decode/control block: opcodes, ALU op classes,
// ALU control words and branch funct3 codes.
package riscv_decode_pkg;

  localparam int unsigned OPC_W  = 7;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned ALUOP_W = 3;
  localparam int unsigned CTRL_W = 5;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;

  localparam logic [ALUOP_W-1:0] ALU_OP_MEM = 3'b000;
  localparam logic [ALUOP_W-1:0] ALU_OP_BR  = 3'b001;
  localparam logic [ALUOP_W-1:0] ALU_OP_R   = 3'b010;
  localparam logic [ALUOP_W-1:0] ALU_OP_I   = 3'b011;

  // {Ainv, Binv, sel[2:0]}
  localparam logic [CTRL_W-1:0] ALU_ADD  = 5'b00010;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 5'b01010;
  localparam logic [CTRL_W-1:0] ALU_AND  = 5'b00000;
  localparam logic [CTRL_W-1:0] ALU_OR   = 5'b00001;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 5'b00011;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 5'b00100;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 5'b00101;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 5'b00110;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 5'b01111;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 5'b11111;

  localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
  localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
  localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
  localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
  localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/riscv_decode_ctrl_branch_cmp.sv
// Branch condition evaluator: compares rs1/rs2 per branch funct3 and flags
// the two reserved funct3 codes.
module branch_cmp
  import riscv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] rd1,
  input  logic [XLEN-1:0] rd2,
  input  logic [F3_W-1:0] funct3,
  output logic            cond,
  output logic            illegal_f3
);

  logic w_eq;
  logic w_lt_s;
  logic w_lt_u;

  assign w_eq   = (rd1 == rd2);
  assign w_lt_s = ($signed(rd1) < $signed(rd2));
  assign w_lt_u = (rd1 < rd2);

  always_comb begin
    cond       = 1'b0;
    illegal_f3 = 1'b0;
    case (funct3)
      F3_BEQ:  cond = w_eq;
      F3_BNE:  cond = !w_eq;
      F3_BLT:  cond = w_lt_s;
      F3_BGE:  cond = !w_lt_s;
      F3_BLTU: cond = w_lt_u;
      F3_BGEU: cond = !w_lt_u;
      default: illegal_f3 = 1'b1;
    endcase
  end

endmodule

// File: rtl/riscv_decode_ctrl.sv
// Single-cycle RV32I main decoder, ALU-control decoder and branch resolver with
// a sticky illegal flag. Define DECODE_BRANCH_CNT_EN to add the taken-branch counter.
module riscv_decode_ctrl
  import riscv_decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [F3_W-1:0]     funct3,
  input  logic                funct7b5,
  input  logic [XLEN-1:0]     rd1,
  input  logic [XLEN-1:0]     rd2,
  output logic                branch,
  output logic                mem_read,
  output logic                mem_to_reg,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_write,
  output logic [CTRL_W-1:0]   alu_ctrl,
  output logic                branch_taken,
  output logic                illegal,
`ifdef DECODE_BRANCH_CNT_EN
  output logic [31:0]         taken_count,
`endif
  output logic                illegal_sticky
);

  logic w_bad_opcode;
  logic w_is_branch;
  logic w_cond;
  logic w_illegal_f3;
  logic r_illegal_sticky;

  // Main decode
  always_comb begin
    reg_write    = 1'b0;
    alu_src      = 1'b0;
    mem_to_reg   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    branch       = 1'b0;
    alu_op       = ALU_OP_MEM;
    w_bad_opcode = 1'b0;
    case (opcode)
      OP_R: begin
        reg_write = 1'b1;
        alu_op    = ALU_OP_R;
      end
      OP_I: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = ALU_OP_I;
      end
      OP_LOAD: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        mem_to_reg = 1'b1;
        mem_read   = 1'b1;
      end
      OP_STORE: begin
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      OP_BRANCH: begin
        branch = 1'b1;
        alu_op = ALU_OP_BR;
      end
      default: w_bad_opcode = 1'b1;
    endcase
  end

  // ALU control; funct7b5 only selects SUB for register-register ops
  always_comb begin
    alu_ctrl = ALU_ADD;
    if (alu_op == ALU_OP_BR) begin
      alu_ctrl = ALU_SUB;
    end else if ((alu_op == ALU_OP_R) || (alu_op == ALU_OP_I)) begin
      case (funct3)
        3'b000:  alu_ctrl = ((alu_op == ALU_OP_R) && funct7b5) ? ALU_SUB : ALU_ADD;
        3'b001:  alu_ctrl = ALU_SLL;
        3'b010:  alu_ctrl = ALU_SLT;
        3'b011:  alu_ctrl = ALU_SLTU;
        3'b100:  alu_ctrl = ALU_XOR;
        3'b101:  alu_ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
        3'b110:  alu_ctrl = ALU_OR;
        default: alu_ctrl = ALU_AND;
      endcase
    end
  end

  branch_cmp #(
    .XLEN(XLEN)
  ) u_branch_cmp (
    .rd1       (rd1),
    .rd2       (rd2),
    .funct3    (funct3),
    .cond      (w_cond),
    .illegal_f3(w_illegal_f3)
  );

  assign w_is_branch  = (opcode == OP_BRANCH);
  assign branch_taken = w_is_branch & w_cond;
  assign illegal      = w_bad_opcode | (w_is_branch & w_illegal_f3);

  // Sticky illegal flag; reset wins over a simultaneous illegal
  always_ff @(posedge clock) begin
    if (reset) begin
      r_illegal_sticky <= 1'b0;
    end else if (illegal) begin
      r_illegal_sticky <= 1'b1;
    end
  end

  assign illegal_sticky = r_illegal_sticky;

`ifdef DECODE_BRANCH_CNT_EN
  localparam int unsigned CNT_W = 32;
  logic [CNT_W-1:0] r_taken_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_taken_count <= '0;
    end else if (branch_taken) begin
      r_taken_count <= r_taken_count + CNT_W'(1);
    end
  end

  assign taken_count = r_taken_count;
`endif

endmodule

// File: tb/tb_riscv_decode_ctrl.sv
// Self-checking bench for riscv_decode_ctrl: directed vector table, sticky-flag
// sequences and randomized decode against a behavioural model.
module tb_riscv_decode_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [31:0] rd1, rd2;
  logic        branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [2:0]  alu_op;
  logic [4:0]  alu_ctrl;
  logic        branch_taken, illegal, illegal_sticky;
`ifdef DECODE_BRANCH_CNT_EN
  logic [31:0] taken_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  riscv_decode_ctrl #(.XLEN(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .funct7b5      (funct7b5),
    .rd1           (rd1),
    .rd2           (rd2),
    .branch        (branch),
    .mem_read      (mem_read),
    .mem_to_reg    (mem_to_reg),
    .alu_op        (alu_op),
    .mem_write     (mem_write),
    .alu_src       (alu_src),
    .reg_write     (reg_write),
    .alu_ctrl      (alu_ctrl),
    .branch_taken  (branch_taken),
    .illegal       (illegal),
`ifdef DECODE_BRANCH_CNT_EN
    .taken_count   (taken_count),
`endif
    .illegal_sticky(illegal_sticky)
  );

  // Packed view: {rw, src, m2r, mrd, mwr, br, alu_op[2:0], alu_ctrl[4:0], taken, illegal}
  function automatic logic [15:0] dut_vec();
    return {reg_write, alu_src, mem_to_reg, mem_read, mem_write, branch,
            alu_op, alu_ctrl, branch_taken, illegal};
  endfunction

  function automatic logic [4:0] ctrl_of(input string mn);
    case (mn)
      "ADD":   return 5'b00010;
      "SUB":   return 5'b01010;
      "AND":   return 5'b00000;
      "OR":    return 5'b00001;
      "XOR":   return 5'b00011;
      "SLL":   return 5'b00100;
      "SRL":   return 5'b00101;
      "SRA":   return 5'b00110;
      "SLT":   return 5'b01111;
      default: return 5'b11111;
    endcase
  endfunction

  // Reference: decode the instruction as an assembler would name it
  function automatic logic [15:0] model(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7, input logic [31:0] a, input logic [31:0] b);
    string names [8] = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
    logic [5:0] strobes = 6'b0;
    logic [2:0] aop = 3'b000;
    string      mn = "ADD";
    logic       tk = 1'b0;
    logic       il = 1'b0;
    case (op)
      7'b0110011: begin
        strobes = 6'b100000; aop = 3'b010;
        mn = names[f3];
        if (f3 == 3'd0 && f7) mn = "SUB";
        if (f3 == 3'd5 && f7) mn = "SRA";
      end
      7'b0010011: begin
        strobes = 6'b110000; aop = 3'b011;
        mn = names[f3];
        if (f3 == 3'd5 && f7) mn = "SRA";
      end
      7'b0000011: strobes = 6'b111100;
      7'b0100011: strobes = 6'b010010;
      7'b1100011: begin
        strobes = 6'b000001; aop = 3'b001; mn = "SUB";
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: il = 1'b1;
        endcase
      end
      default: il = 1'b1;
    endcase
    return {strobes, aop, ctrl_of(mn), tk, il};
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                       input logic [31:0] a, input logic [31:0] b);
    opcode = op; funct3 = f3; funct7b5 = f7; rd1 = a; rd2 = b;
  endtask

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs [14];

  logic        m_sticky;
  logic [31:0] m_cnt;
  logic [15:0] m_exp;
  logic [6:0]  ops [5] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

  initial begin
    vecs[0]  = '{"r_sub",    7'b0110011, 3'b000, 1'b1, 32'h0, 32'h0, 16'b100000_010_01010_0_0};
    vecs[1]  = '{"addi_f7",  7'b0010011, 3'b000, 1'b1, 32'h0, 32'h0, 16'b110000_011_00010_0_0};
    vecs[2]  = '{"srai",     7'b0010011, 3'b101, 1'b1, 32'h0, 32'h0, 16'b110000_011_00110_0_0};
    vecs[3]  = '{"load",     7'b0000011, 3'b010, 1'b0, 32'h0, 32'h0, 16'b111100_000_00010_0_0};
    vecs[4]  = '{"store",    7'b0100011, 3'b010, 1'b0, 32'h0, 32'h0, 16'b010010_000_00010_0_0};
    vecs[5]  = '{"blt_neg",  7'b1100011, 3'b100, 1'b0, 32'hFFFFFFFF, 32'h1, 16'b000001_001_01010_1_0};
    vecs[6]  = '{"bltu_neg", 7'b1100011, 3'b110, 1'b0, 32'hFFFFFFFF, 32'h1, 16'b000001_001_01010_0_0};
    vecs[7]  = '{"bgeu_neg", 7'b1100011, 3'b111, 1'b0, 32'hFFFFFFFF, 32'h1, 16'b000001_001_01010_1_0};
    vecs[8]  = '{"beq_eq",   7'b1100011, 3'b000, 1'b0, 32'h5, 32'h5, 16'b000001_001_01010_1_0};
    vecs[9]  = '{"bad_op",   7'b1111111, 3'b000, 1'b0, 32'h5, 32'h5, 16'b000000_000_00010_0_1};
    vecs[10] = '{"br_f3_2",  7'b1100011, 3'b010, 1'b0, 32'h5, 32'h5, 16'b000001_001_01010_0_1};
    vecs[11] = '{"r_sltu",   7'b0110011, 3'b011, 1'b0, 32'h0, 32'h0, 16'b100000_010_11111_0_0};
    vecs[12] = '{"r_srl",    7'b0110011, 3'b101, 1'b0, 32'h0, 32'h0, 16'b100000_010_00101_0_0};
    vecs[13] = '{"slti",     7'b0010011, 3'b010, 1'b1, 32'h0, 32'h0, 16'b110000_011_01111_0_0};

    reset = 1'b1;
    drive(7'b0110011, 3'b000, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clock);
    #1;
    check("reset_sticky", 32'(illegal_sticky), 32'd0);
`ifdef DECODE_BRANCH_CNT_EN
    check("reset_count", taken_count, 32'd0);
`endif

    @(negedge clock);
    reset = 1'b0;
    foreach (vecs[i]) begin
      @(negedge clock);
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
      #1;
      check(vecs[i].name, 32'(dut_vec()), 32'(vecs[i].exp));
    end

    // Sticky flag: set, hold across legal ops, cleared by reset even with illegal present
    @(negedge clock);
    reset = 1'b1;
    drive(7'b0110011, 3'b000, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    check("sticky_clr", 32'(illegal_sticky), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(7'b1111111, 3'b000, 1'b0, 32'h0, 32'h0);
    #1;
    check("sticky_pre", 32'(illegal_sticky), 32'd0);
    @(posedge clock); #1;
    check("sticky_set", 32'(illegal_sticky), 32'd1);
    @(negedge clock);
    drive(7'b0010011, 3'b001, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clock);
    #1;
    check("sticky_hold", 32'(illegal_sticky), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    drive(7'b1111111, 3'b000, 1'b0, 32'h0, 32'h0);
    #1;
    check("comb_in_reset", 32'(illegal), 32'd1);
    @(posedge clock); #1;
    check("sticky_rst_wins", 32'(illegal_sticky), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    drive(7'b0000011, 3'b010, 1'b0, 32'h0, 32'h0);
    @(posedge clock); #1;
    check("sticky_stay0", 32'(illegal_sticky), 32'd0);

`ifdef DECODE_BRANCH_CNT_EN
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    drive(7'b1100011, 3'b000, 1'b0, 32'h7, 32'h7);
    repeat (3) @(posedge clock);
    @(negedge clock);
    drive(7'b0110011, 3'b000, 1'b0, 32'h7, 32'h7);
    @(posedge clock); #1;
    check("count_3", taken_count, 32'd3);
    @(negedge clock);
    force dut.r_taken_count = 32'hFFFFFFFF;
    #1;
    release dut.r_taken_count;
    drive(7'b1100011, 3'b001, 1'b0, 32'h1, 32'h2);
    @(posedge clock); #1;
    check("count_wrap", taken_count, 32'd0);
`endif

    // Randomized decode plus sticky/counter tracking
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    m_sticky = 1'b0;
    m_cnt    = 32'd0;
    for (int n = 0; n < 400; n++) begin
      logic [6:0]  op;
      logic [31:0] a, b;
      @(negedge clock);
      reset = ($urandom_range(0, 19) == 0);
      op = ($urandom_range(0, 5) == 5) ? 7'($urandom) : ops[$urandom_range(0, 4)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ 32'h8000_0000;
        default: b = $urandom;
      endcase
      drive(op, 3'($urandom), 1'($urandom), a, b);
      #1;
      m_exp = model(opcode, funct3, funct7b5, rd1, rd2);
      check("rand_decode", 32'(dut_vec()), 32'(m_exp));
      @(posedge clock); #1;
      if (reset) begin
        m_sticky = 1'b0;
        m_cnt    = 32'd0;
      end else begin
        if (m_exp[0]) m_sticky = 1'b1;
        if (m_exp[1]) m_cnt = m_cnt + 32'd1;
      end
      check("rand_sticky", 32'(illegal_sticky), 32'(m_sticky));
`ifdef DECODE_BRANCH_CNT_EN
      check("rand_count", taken_count, m_cnt);
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
